// File: rtl/bp_lookup_update_scheduler.sv
// Schedules lookups and training updates onto the single port of a branch predictor,
// tracking in-flight branches in program order and counting branches/mispredictions.
module bp_lookup_update_scheduler #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IP_W  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     req_valid,
    input  logic [IP_W-1:0]          req_ip,
    output logic                     req_ready,
    output logic                     pred_valid,
    output logic                     pred_taken,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic [IP_W-1:0]          tbl_ip,
    output logic                     tbl_upd,
    output logic                     tbl_taken,
    input  logic                     tbl_pred,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispred_cnt,
    output logic                     err_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [IP_W-1:0]  ip_mem [DEPTH];
    logic [DEPTH-1:0] pred_mem;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic             pred_valid_q, pred_taken_q;
    logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;
    logic             err_q;

    logic empty, full, do_upd, do_lookup, underflow, head_pred;

    assign empty     = (count_q == '0);
    assign full      = (count_q == OCC_W'(DEPTH));
    assign do_upd    = !flush && res_valid && !empty;
    assign underflow = !flush && res_valid && empty;
    // Ready depends combinationally on res_valid: an update owns the port this cycle.
    assign req_ready = !flush && !full && !(res_valid && !empty);
    assign do_lookup = req_valid && req_ready;
    assign head_pred = pred_mem[rd_ptr_q];

    always_comb begin
        tbl_upd   = 1'b0;
        tbl_ip    = '0;
        tbl_taken = 1'b0;
        if (do_upd) begin
            tbl_upd   = 1'b1;
            tbl_ip    = ip_mem[rd_ptr_q];
            tbl_taken = res_taken;
        end else if (do_lookup) begin
            tbl_ip = req_ip;
        end
    end

    always_ff @(posedge clk) begin
        if (do_lookup) begin
            ip_mem[wr_ptr_q]   <= req_ip;
            pred_mem[wr_ptr_q] <= tbl_pred;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Update and lookup are mutually exclusive, so occupancy moves by at most one.
            if (do_lookup) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + 1'b1;
            end else if (do_upd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q  <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            pred_valid_q <= do_lookup;
            if (do_lookup) begin
                pred_taken_q <= tbl_pred;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (do_upd && branch_cnt_q != '1) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (do_upd && head_pred != res_taken && mispred_cnt_q != '1) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
            if (underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pred_valid    = pred_valid_q;
    assign pred_taken    = pred_taken_q;
    assign inflight      = count_q;
    assign branch_cnt    = branch_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_bp_lookup_update_scheduler.sv
// Randomized scoreboard bench for bp_lookup_update_scheduler against a queue-based model.
module tb_bp_lookup_update_scheduler;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned IP_W  = 64;
    localparam int unsigned CNT_W = 5;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0, req_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
    logic             tbl_pred = 1'b0;
    logic [IP_W-1:0]  req_ip = '0;
    logic             req_ready, pred_valid, pred_taken, tbl_upd, tbl_taken, err_underflow;
    logic [IP_W-1:0]  tbl_ip;
    logic [$clog2(DEPTH):0] inflight;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    bp_lookup_update_scheduler #(.DEPTH(DEPTH), .IP_W(IP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .req_valid(req_valid), .req_ip(req_ip),
        .req_ready(req_ready), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .tbl_ip(tbl_ip), .tbl_upd(tbl_upd),
        .tbl_taken(tbl_taken), .tbl_pred(tbl_pred), .inflight(inflight),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IP_W-1:0] ip;
        logic            pred;
    } ent_t;

    ent_t            model_q[$];
    ent_t            exp_upd[$];
    logic            exp_pred[$];
    longint unsigned m_branch, m_mispred;
    logic            m_err;
    logic            in_rst = 1'b1;
    int              chk_cnt = 0, pass_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock of stimulus; the model decides the cycle from the rules and advances.
    task automatic step(input logic f, input logic rv, input logic rt, input logic qv,
                        input logic [IP_W-1:0] ip, input logic pr);
        bit upd, und, rdy, lk;
        ent_t e;
        @(negedge clk);
        flush = f; res_valid = rv; res_taken = rt; req_valid = qv; req_ip = ip; tbl_pred = pr;
        #1;
        chk("inflight", 64'(inflight), 64'(model_q.size()));
        chk("branch_cnt", 64'(branch_cnt), m_branch);
        chk("mispred_cnt", 64'(mispred_cnt), m_mispred);
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
        upd = !f && rv && model_q.size() > 0;
        und = !f && rv && model_q.size() == 0;
        rdy = !f && model_q.size() < DEPTH && !upd;
        lk  = qv && rdy;
        chk("req_ready", 64'(req_ready), 64'(rdy));
        if (!upd) chk("tbl_ip_lookup", tbl_ip, lk ? ip : '0);
        if (upd) begin
            e = model_q.pop_front();
            exp_upd.push_back('{ip: e.ip, pred: rt});
            if (m_branch < CNT_MAX) m_branch++;
            if (e.pred != rt && m_mispred < CNT_MAX) m_mispred++;
        end
        if (und) m_err = 1'b1;
        if (f) model_q.delete();
        if (lk) begin
            model_q.push_back('{ip: ip, pred: pr});
            exp_pred.push_back(pr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; in_rst = 1'b1;
        flush = 0; res_valid = 0; res_taken = 0; req_valid = 0; req_ip = '0; tbl_pred = 0;
        #1;
        chk("rst_inflight", 64'(inflight), 0);
        chk("rst_pred_valid", 64'(pred_valid), 0);
        chk("rst_pred_taken", 64'(pred_taken), 0);
        chk("rst_tbl_upd", 64'(tbl_upd), 0);
        chk("rst_tbl_ip", tbl_ip, 0);
        chk("rst_tbl_taken", 64'(tbl_taken), 0);
        chk("rst_branch_cnt", 64'(branch_cnt), 0);
        chk("rst_mispred_cnt", 64'(mispred_cnt), 0);
        chk("rst_err", 64'(err_underflow), 0);
        model_q.delete(); exp_upd.delete(); exp_pred.delete();
        m_branch = 0; m_mispred = 0; m_err = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; in_rst = 1'b0;
    endtask

    // Update monitor: the port event must match the oldest expected training update.
    always begin
        ent_t e;
        @(negedge clk); #2;
        if (!in_rst) begin
            chk("tbl_upd_event", 64'(tbl_upd), 64'(exp_upd.size() != 0));
            if (exp_upd.size() != 0) begin
                e = exp_upd.pop_front();
                if (tbl_upd) begin
                    chk("upd_tbl_ip", tbl_ip, e.ip);
                    chk("upd_tbl_taken", 64'(tbl_taken), 64'(e.pred));
                end
            end
        end
    end

    // Prediction monitor: one cycle after an accepted lookup.
    always begin
        logic p;
        @(posedge clk); #1;
        if (!in_rst) begin
            chk("pred_valid", 64'(pred_valid), 64'(exp_pred.size() != 0));
            if (exp_pred.size() != 0) begin
                p = exp_pred.pop_front();
                if (pred_valid) chk("pred_taken", 64'(pred_taken), 64'(p));
            end
        end
    end

    initial begin
        do_reset();
        // Single lookup then a mispredicted resolve.
        step(0, 0, 0, 1, 64'h40, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("inflight_one", 64'(inflight), 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("mispred_one", 64'(mispred_cnt), 1);
        // Fill the queue, 9th lookup refused, then update wins over a concurrent lookup.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 64'h100 + 64'(i), i[0]);
        step(0, 0, 0, 1, 64'h200, 1);
        chk("full_not_ready", 64'(req_ready), 0);
        step(0, 1, 1, 1, 64'h200, 1);
        step(0, 0, 0, 1, 64'h200, 1);
        for (int i = 0; i < 8; i++) step(0, 1, $urandom_range(0, 1), 0, 0, 0);
        // Resolve with an empty queue.
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("underflow_sticky", 64'(err_underflow), 1);
        // Flush overrides a concurrent resolve and lookup.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 64'h300 + 64'(i), 0);
        step(1, 1, 1, 1, 64'h999, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_empty", 64'(inflight), 0);
        // Reset mid-stream with three entries, then immediate acceptance.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 64'h500 + 64'(i), 1);
        do_reset();
        step(0, 0, 0, 1, 64'h600, 1);
        step(0, 1, 1, 0, 0, 0);
        do_reset();
        // Twenty lookup/resolve pairs crossing the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, 64'h1000 + 64'(i * 4), 1);
            step(0, 1, i[0], 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_branch_cnt", 64'(branch_cnt), 20);
        chk("wrap_mispred_cnt", 64'(mispred_cnt), 10);
        // Random traffic, including counter saturation and one mid-stream reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step($urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
                 $urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'($urandom));
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
